// File: rtl/lzw_pkg.sv
// Shared widths and transmit FSM states for the LZW
// compressor datapath (tx packer, rx unpacker).
package lzw_pkg;

   localparam int CODE_W = 12;
   localparam int BYTE_W = 8;

   typedef enum logic [1:0] {
      IDLE,
      SEND,
      DROP
   } tx_state_t;

endpackage

// File: rtl/byte_fifo.sv
// Single-clock FIFO with first-word-fall-through read data.
// Pointers carry one extra wrap bit to tell full from empty.
module byte_fifo #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]      wptr;
   logic [AW:0]      rptr;
   logic [WIDTH-1:0] mem [DEPTH];

   assign empty = (wptr == rptr);
   assign full  = (wptr[AW] != rptr[AW]) &&
                  (wptr[AW-1:0] == rptr[AW-1:0]);
   assign rdata = mem[rptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (push && !full) begin
         mem[wptr[AW-1:0]] <= wdata;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (push && !full) begin
            wptr <= wptr + {{AW{1'b0}}, 1'b1};
         end
         if (pop && !empty) begin
            rptr <= rptr + {{AW{1'b0}}, 1'b1};
         end
      end
   end

endmodule

// File: rtl/code_tx_packer.sv
// Packs 12-bit LZW codes two-per-three-bytes, MSB-first, and
// feeds them one at a time to the UART transmitter handshake.
module code_tx_packer
   import lzw_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [CODE_W-1:0] code_in,
   input  logic              code_vld,
   output logic              code_rdy,
   input  logic              flush,
   output logic              flush_done,
   output logic              start_xmt,
   output logic [BYTE_W-1:0] xmt_byte,
   input  logic              xmt_done,
   output logic              busy
);

   logic [3:0]        nib;
   logic              nib_vld;
   logic [BYTE_W-1:0] hold;
   logic              hold_vld;
   logic              flush_pend;

   logic              fifo_full;
   logic              fifo_empty;
   logic [BYTE_W-1:0] fifo_rdata;
   logic              push;
   logic              pop;
   logic [BYTE_W-1:0] wdata;

   logic              accept;
   logic              hold_push;
   logic              pad_push;

   tx_state_t state;
   tx_state_t state_n;

   assign code_rdy  = ~fifo_full & ~hold_vld & ~flush_pend;
   assign accept    = code_vld & code_rdy;
   assign hold_push = hold_vld & ~fifo_full;
   assign pad_push  = flush_pend & nib_vld &
                      ~hold_vld & ~fifo_full;

   assign flush_done = flush_pend & ~nib_vld & ~hold_vld &
                       fifo_empty & (state == IDLE);

   assign start_xmt = (state == SEND);
   assign busy      = ~fifo_empty | nib_vld | hold_vld |
                      (state != IDLE);

   // accept needs ~hold_vld and ~flush_pend, so sources are exclusive
   always_comb begin
      push  = 1'b0;
      wdata = '0;
      unique case (1'b1)
         hold_push: begin
            push  = 1'b1;
            wdata = hold;
         end
         accept: begin
            push  = 1'b1;
            wdata = nib_vld ? {nib, code_in[11:8]}
                            : code_in[11:4];
         end
         pad_push: begin
            push  = 1'b1;
            wdata = {nib, 4'h0};
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         nib        <= '0;
         nib_vld    <= 1'b0;
         hold       <= '0;
         hold_vld   <= 1'b0;
         flush_pend <= 1'b0;
      end else begin
         if (accept) begin
            if (nib_vld) begin
               hold     <= code_in[7:0];
               hold_vld <= 1'b1;
               nib_vld  <= 1'b0;
            end else begin
               nib     <= code_in[3:0];
               nib_vld <= 1'b1;
            end
         end else if (pad_push) begin
            nib_vld <= 1'b0;
         end
         if (hold_push) begin
            hold_vld <= 1'b0;
         end
         flush_pend <= flush | (flush_pend & ~flush_done);
      end
   end

   byte_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (BYTE_W)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .wdata (wdata),
      .pop   (pop),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         xmt_byte <= '0;
      end else begin
         state <= state_n;
         if (pop) begin
            xmt_byte <= fifo_rdata;
         end
      end
   end

   // DROP waits for the serial block to release xmt_done
   always_comb begin
      state_n = state;
      pop     = 1'b0;
      unique case (state)
         IDLE: begin
            if (!fifo_empty) begin
               pop     = 1'b1;
               state_n = SEND;
            end
         end
         SEND: begin
            if (xmt_done) begin
               state_n = DROP;
            end
         end
         DROP: begin
            if (!xmt_done) begin
               state_n = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

endmodule

// File: tb/tb_code_tx_packer.sv
// Directed bench for code_tx_packer with a behavioural
// serial transmitter answering the start_xmt/xmt_done handshake.
module tb_code_tx_packer;

   logic        clk;
   logic        rst_n;
   logic [11:0] code_in;
   logic        code_vld;
   logic        code_rdy;
   logic        flush;
   logic        flush_done;
   logic        start_xmt;
   logic [7:0]  xmt_byte;
   logic        xmt_done;
   logic        busy;

   int n_chk;
   int n_err;

   int dly;
   int hold_extra;
   logic [7:0] rx [$];
   logic [7:0] exp_q [$];
   int unstable;
   int drop_viol;
   int fd_cnt;
   int fd_long;
   int fd_xmt;
   int bytes_at_fd;
   int max_wait;

   code_tx_packer #(.DEPTH(8)) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .code_in    (code_in),
      .code_vld   (code_vld),
      .code_rdy   (code_rdy),
      .flush      (flush),
      .flush_done (flush_done),
      .start_xmt  (start_xmt),
      .xmt_byte   (xmt_byte),
      .xmt_done   (xmt_done),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h",
                  tag, obs, exp);
      end
   endtask

   // serial transmitter model
   initial begin
      int phase;
      int cnt;
      logic [7:0] cap;
      logic prev_fd;
      phase   = 0;
      cnt     = 0;
      cap     = '0;
      prev_fd = 1'b0;
      xmt_done = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            phase    = 0;
            cnt      = 0;
            xmt_done = 1'b0;
            prev_fd  = 1'b0;
            continue;
         end
         if (flush_done) begin
            fd_cnt++;
            bytes_at_fd = rx.size();
            if (prev_fd) fd_long++;
            if (start_xmt) fd_xmt++;
         end
         prev_fd = flush_done;
         if (start_xmt && phase != 0 && phase != 3 &&
             xmt_byte != cap) unstable++;
         case (phase)
            0: if (start_xmt) begin
               cap = xmt_byte;
               rx.push_back(xmt_byte);
               cnt = 0;
               phase = 1;
            end
            1: begin
               cnt++;
               if (cnt >= dly) begin
                  xmt_done = 1'b1;
                  phase = 2;
               end
            end
            2: if (!start_xmt) begin
               cnt = 0;
               phase = 3;
            end
            default: begin
               if (start_xmt) drop_viol++;
               cnt++;
               if (cnt >= hold_extra) begin
                  xmt_done = 1'b0;
                  phase = 0;
               end
            end
         endcase
      end
   end

   task automatic clear_stats();
      rx.delete();
      exp_q.delete();
      unstable    = 0;
      drop_viol   = 0;
      fd_cnt      = 0;
      fd_long     = 0;
      fd_xmt      = 0;
      bytes_at_fd = -1;
      max_wait    = 0;
   endtask

   task automatic push_code(input logic [11:0] c,
                            input bit f);
      int n;
      n = 0;
      code_in  = c;
      code_vld = 1'b1;
      while (!code_rdy && n < 2000) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 2000) chk("code_rdy_timeout", n, 0);
      if (n > max_wait) max_wait = n;
      flush = f;
      @(posedge clk); #1;
      code_vld = 1'b0;
      flush    = 1'b0;
   endtask

   task automatic do_flush();
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
   endtask

   task automatic wait_fd(input string tag);
      int n;
      n = 0;
      while (fd_cnt == 0 && n < 20000) begin
         @(posedge clk); #1;
         n++;
      end
      chk({tag, "_fd_timeout"}, 32'(n < 20000), 1);
      repeat (30) @(posedge clk);
      #1;
   endtask

   task automatic exp_codes(input logic [11:0] c [$]);
      for (int i = 0; i < c.size(); i += 2) begin
         exp_q.push_back(c[i][11:4]);
         if (i + 1 < c.size()) begin
            exp_q.push_back({c[i][3:0], c[i+1][11:8]});
            exp_q.push_back(c[i+1][7:0]);
         end else begin
            exp_q.push_back({c[i][3:0], 4'h0});
         end
      end
   endtask

   task automatic cmp_bytes(input string tag);
      chk({tag, "_nbytes"}, rx.size(), exp_q.size());
      for (int i = 0; i < exp_q.size(); i++) begin
         if (i < rx.size())
            chk($sformatf("%s_b%0d", tag, i), rx[i], exp_q[i]);
      end
   endtask

   task automatic cmp_flush(input string tag);
      chk({tag, "_fd_pulses"}, fd_cnt, 1);
      chk({tag, "_fd_long"}, fd_long, 0);
      chk({tag, "_fd_xmt"}, fd_xmt, 0);
      chk({tag, "_fd_after"}, bytes_at_fd, exp_q.size());
      chk({tag, "_unstable"}, unstable, 0);
   endtask

   initial begin
      logic [11:0] cq [$];
      n_chk = 0;
      n_err = 0;
      rst_n = 1'b0;
      code_in = '0;
      code_vld = 1'b0;
      flush = 1'b0;
      dly = 5;
      hold_extra = 1;
      clear_stats();
      repeat (3) @(posedge clk);
      #1;
      chk("rst_code_rdy", code_rdy, 1);
      chk("rst_start_xmt", start_xmt, 0);
      chk("rst_xmt_byte", xmt_byte, 8'h00);
      chk("rst_busy", busy, 0);
      chk("rst_flush_done", flush_done, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // two codes
      clear_stats();
      push_code(12'hABC, 1'b0);
      chk("two_busy", busy, 1);
      push_code(12'h123, 1'b0);
      do_flush();
      wait_fd("two");
      cq = '{12'hABC, 12'h123};
      exp_codes(cq);
      cmp_bytes("two");
      cmp_flush("two");
      chk("two_idle_busy", busy, 0);

      // odd count, padded
      clear_stats();
      push_code(12'h5A7, 1'b0);
      do_flush();
      wait_fd("odd");
      cq = '{12'h5A7};
      exp_codes(cq);
      cmp_bytes("odd");
      cmp_flush("odd");

      // backpressure
      clear_stats();
      dly = 200;
      cq = '{12'h0F1, 12'hE2D, 12'h3C4, 12'hB5A,
             12'h697, 12'h888, 12'h7A5, 12'h4B3,
             12'hC1E, 12'h2D0};
      foreach (cq[i]) push_code(cq[i], 1'b0);
      chk("bp_stalled", 32'(max_wait > 50), 1);
      do_flush();
      wait_fd("bp");
      exp_codes(cq);
      cmp_bytes("bp");
      cmp_flush("bp");

      // xmt_done held high after start_xmt falls
      clear_stats();
      dly = 3;
      hold_extra = 20;
      cq = '{12'h9E1, 12'h47C};
      foreach (cq[i]) push_code(cq[i], 1'b0);
      do_flush();
      wait_fd("hs");
      exp_codes(cq);
      cmp_bytes("hs");
      cmp_flush("hs");
      chk("hs_drop_viol", drop_viol, 0);
      hold_extra = 1;

      // flush together with first code of a pair
      clear_stats();
      dly = 5;
      push_code(12'hFFF, 1'b1);
      chk("ovl_rdy_low", code_rdy, 0);
      wait_fd("ovl");
      cq = '{12'hFFF};
      exp_codes(cq);
      cmp_bytes("ovl");
      cmp_flush("ovl");
      chk("ovl_rdy_back", code_rdy, 1);

      // reset in the middle of a frame
      clear_stats();
      dly = 50;
      cq = '{12'h111, 12'h222, 12'h333, 12'h444};
      foreach (cq[i]) push_code(cq[i], 1'b0);
      repeat (5) @(posedge clk);
      #1;
      chk("mid_sending", start_xmt, 1);
      rst_n = 1'b0;
      #1;
      chk("mid_start_xmt", start_xmt, 0);
      chk("mid_busy", busy, 0);
      chk("mid_xmt_byte", xmt_byte, 8'h00);
      chk("mid_code_rdy", code_rdy, 1);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      clear_stats();
      dly = 5;
      push_code(12'h001, 1'b0);
      do_flush();
      wait_fd("post");
      cq = '{12'h001};
      exp_codes(cq);
      cmp_bytes("post");
      cmp_flush("post");

      $display("Simulation finished: %0d checks, %0d errors",
               n_chk, n_err);
      $finish;
   end

endmodule
